// File: rtl/pipelined_control_unit_pkg.sv
// Shared decode constants, ALU operation encodings and per-stage control bundles
// for the five-stage pipelined control unit.
package pipelined_control_unit_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_BEQ   = 6'b000100;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_SLT   = 6'b101010;

   typedef enum logic [3:0] {
      ALU_AND = 4'b0000,
      ALU_OR  = 4'b0001,
      ALU_ADD = 4'b0010,
      ALU_SUB = 4'b0110,
      ALU_SLT = 4'b0111
   } alu_op_e;

   typedef struct packed {
      logic    alu_src;
      logic    branch;
      alu_op_e alu_op;
      logic    mem_read;
      logic    mem_write;
      logic    reg_write;
      logic    mem_to_reg;
   } ctrl_t;

   typedef struct packed {
      logic mem_read;
      logic mem_write;
      logic reg_write;
      logic mem_to_reg;
   } mem_ctrl_t;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
   } wb_ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   function automatic mem_ctrl_t to_mem(input ctrl_t c);
      mem_ctrl_t m;
      m.mem_read   = c.mem_read;
      m.mem_write  = c.mem_write;
      m.reg_write  = c.reg_write;
      m.mem_to_reg = c.mem_to_reg;
      return m;
   endfunction

   function automatic wb_ctrl_t to_wb(input mem_ctrl_t m);
      wb_ctrl_t w;
      w.reg_write  = m.reg_write;
      w.mem_to_reg = m.mem_to_reg;
      return w;
   endfunction

endpackage

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational instruction decoder: opcode/funct fields to a control bundle,
// destination register, rt-usage flag and an unknown-instruction flag.
module ctrl_decoder
   import pipelined_control_unit_pkg::*;
#(
   parameter int unsigned REG_W = 5
) (
   input  logic [5:0]       opcode_i,
   input  logic [5:0]       funct_i,
   input  logic [4:0]       rt_i,
   input  logic [4:0]       rd_i,
   output ctrl_t            ctrl_o,
   output logic [REG_W-1:0] wdest_o,
   output logic             reads_rt_o,
   output logic             illegal_o
);

   ctrl_t      ctrl_s;
   logic       use_rd_s;
   logic       reads_rt_s;
   logic       illegal_s;
   logic [4:0] dest_raw_s;

   // Raw opcode/funct decode; unknown encodings collapse to an all-zero bundle.
   always_comb begin
      ctrl_s     = CTRL_BUBBLE;
      use_rd_s   = 1'b0;
      reads_rt_s = 1'b0;
      illegal_s  = 1'b0;
      case (opcode_i)
         OP_RTYPE: begin
            use_rd_s         = 1'b1;
            reads_rt_s       = 1'b1;
            ctrl_s.reg_write = 1'b1;
            case (funct_i)
               FN_ADD:  ctrl_s.alu_op = ALU_ADD;
               FN_SUB:  ctrl_s.alu_op = ALU_SUB;
               FN_AND:  ctrl_s.alu_op = ALU_AND;
               FN_OR:   ctrl_s.alu_op = ALU_OR;
               FN_SLT:  ctrl_s.alu_op = ALU_SLT;
               default: begin
                  ctrl_s     = CTRL_BUBBLE;
                  use_rd_s   = 1'b0;
                  reads_rt_s = 1'b0;
                  illegal_s  = 1'b1;
               end
            endcase
         end
         OP_LW: begin
            ctrl_s.alu_src    = 1'b1;
            ctrl_s.alu_op     = ALU_ADD;
            ctrl_s.mem_read   = 1'b1;
            ctrl_s.mem_to_reg = 1'b1;
            ctrl_s.reg_write  = 1'b1;
         end
         OP_SW: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.alu_op    = ALU_ADD;
            ctrl_s.mem_write = 1'b1;
            reads_rt_s       = 1'b1;
         end
         OP_ADDI: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.alu_op    = ALU_ADD;
            ctrl_s.reg_write = 1'b1;
         end
         OP_ANDI: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.alu_op    = ALU_AND;
            ctrl_s.reg_write = 1'b1;
         end
         OP_ORI: begin
            ctrl_s.alu_src   = 1'b1;
            ctrl_s.alu_op    = ALU_OR;
            ctrl_s.reg_write = 1'b1;
         end
         OP_BEQ: begin
            ctrl_s.branch = 1'b1;
            ctrl_s.alu_op = ALU_SUB;
            reads_rt_s    = 1'b1;
         end
         default: begin
            illegal_s = 1'b1;
         end
      endcase
   end

   // Writes to register 0 are dropped so the forwarding unit never matches on it.
   always_comb begin
      ctrl_o     = ctrl_s;
      wdest_o    = '0;
      dest_raw_s = use_rd_s ? rd_i : rt_i;
      if (ctrl_s.reg_write && (dest_raw_s != 5'd0)) begin
         wdest_o = REG_W'(dest_raw_s);
      end else begin
         ctrl_o.reg_write = 1'b0;
         wdest_o          = '0;
      end
   end

   assign reads_rt_o = reads_rt_s;
   assign illegal_o  = illegal_s;

endmodule

// File: rtl/pipelined_control_unit.sv
// ID-stage control unit: decodes the ID instruction, carries control bundles
// through EX/MEM/WB, and detects load-use hazards with a saturating stall counter.
module pipelined_control_unit
   import pipelined_control_unit_pkg::*;
#(
   parameter int unsigned ALUOP_W = 4,
   parameter int unsigned REG_W   = 5,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        id_instr,
   input  logic               id_valid,
   input  logic               flush,
   output logic               stall,
   output logic               illegal,
   output logic               ex_alu_src,
   output logic               ex_branch,
   output logic [ALUOP_W-1:0] ex_alu_op,
   output logic               ex_mem_read,
   output logic               ex_mem_write,
   output logic               mem_mem_read,
   output logic               mem_mem_write,
   output logic               ex_reg_write,
   output logic               mem_reg_write,
   output logic               wb_reg_write,
   output logic               wb_mem_to_reg,
   output logic [REG_W-1:0]   ex_wdest,
   output logic [REG_W-1:0]   mem_wdest,
   output logic [REG_W-1:0]   wb_wdest,
   output logic [CNT_W-1:0]   stall_count
);

   ctrl_t            dec_ctrl_s;
   logic [REG_W-1:0] dec_wdest_s;
   logic             dec_reads_rt_s;
   logic             dec_illegal_s;

   ctrl_t            ex_d, ex_q;
   mem_ctrl_t        mem_d, mem_q;
   wb_ctrl_t         wb_d, wb_q;
   logic [REG_W-1:0] ex_wdest_d, ex_wdest_q;
   logic [REG_W-1:0] mem_wdest_d, mem_wdest_q;
   logic [REG_W-1:0] wb_wdest_d, wb_wdest_q;
   logic             illegal_d, illegal_q;
   logic [CNT_W-1:0] cnt_d, cnt_q;

   logic [REG_W-1:0] rs_s;
   logic [REG_W-1:0] rt_s;
   logic             hazard_s;
   logic             stall_s;
   logic             unused_shamt_s;

   ctrl_decoder #(
      .REG_W (REG_W)
   ) u_decoder (
      .opcode_i   (id_instr[31:26]),
      .funct_i    (id_instr[5:0]),
      .rt_i       (id_instr[20:16]),
      .rd_i       (id_instr[15:11]),
      .ctrl_o     (dec_ctrl_s),
      .wdest_o    (dec_wdest_s),
      .reads_rt_o (dec_reads_rt_s),
      .illegal_o  (dec_illegal_s)
   );

   assign rs_s           = REG_W'(id_instr[25:21]);
   assign rt_s           = REG_W'(id_instr[20:16]);
   assign unused_shamt_s = ^id_instr[10:6];

   // Load-use hazard: the load in EX writes a register the ID instruction reads.
   always_comb begin
      hazard_s = 1'b0;
      if (id_valid && ex_q.mem_read && (ex_wdest_q != '0)) begin
         if (ex_wdest_q == rs_s) begin
            hazard_s = 1'b1;
         end else if (dec_reads_rt_s && (ex_wdest_q == rt_s)) begin
            hazard_s = 1'b1;
         end else begin
            hazard_s = 1'b0;
         end
      end else begin
         hazard_s = 1'b0;
      end
   end

   assign stall_s = hazard_s & ~flush;

   // Next-state for the pipeline registers; flush outranks stall, which outranks illegal.
   always_comb begin
      ex_d       = CTRL_BUBBLE;
      ex_wdest_d = '0;
      illegal_d  = 1'b0;
      if (flush) begin
         ex_d = CTRL_BUBBLE;
      end else if (stall_s) begin
         ex_d = CTRL_BUBBLE;
      end else if (!id_valid) begin
         ex_d = CTRL_BUBBLE;
      end else if (dec_illegal_s) begin
         illegal_d = 1'b1;
      end else begin
         ex_d       = dec_ctrl_s;
         ex_wdest_d = dec_wdest_s;
      end

      mem_d       = to_mem(ex_q);
      mem_wdest_d = ex_wdest_q;
      wb_d        = to_wb(mem_q);
      wb_wdest_d  = mem_wdest_q;

      if (stall_s && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   // Pipeline, illegal-pulse and stall-counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q        <= CTRL_BUBBLE;
         mem_q       <= '0;
         wb_q        <= '0;
         ex_wdest_q  <= '0;
         mem_wdest_q <= '0;
         wb_wdest_q  <= '0;
         illegal_q   <= 1'b0;
         cnt_q       <= '0;
      end else begin
         ex_q        <= ex_d;
         mem_q       <= mem_d;
         wb_q        <= wb_d;
         ex_wdest_q  <= ex_wdest_d;
         mem_wdest_q <= mem_wdest_d;
         wb_wdest_q  <= wb_wdest_d;
         illegal_q   <= illegal_d;
         cnt_q       <= cnt_d;
      end
   end

   assign stall         = stall_s;
   assign illegal       = illegal_q;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_branch     = ex_q.branch;
   assign ex_alu_op     = ALUOP_W'(ex_q.alu_op);
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_reg_write  = ex_q.reg_write;
   assign mem_mem_read  = mem_q.mem_read;
   assign mem_mem_write = mem_q.mem_write;
   assign mem_reg_write = mem_q.reg_write;
   assign wb_reg_write  = wb_q.reg_write;
   assign wb_mem_to_reg = wb_q.mem_to_reg;
   assign ex_wdest      = ex_wdest_q;
   assign mem_wdest     = mem_wdest_q;
   assign wb_wdest      = wb_wdest_q;
   assign stall_count   = cnt_q;

endmodule
